ssd1306_vga_top: RTL and testbench

- Emulates an SSD1306-style monochrome OLED controller that drives a VGA monitor.
- An SPI slave receives a 128x96 bitmap in SSD1306 page format and stores it in a 1536-byte bitmap RAM.
- A 640x480@60 Hz VGA timing generator scans the RAM and shows each bitmap pixel as a 5x5 block.
- This is the top level of the FPGA design, clocked at 25.175 MHz.

---
 rtl/ssd1306_vga_top.sv | 204 ++++++++++++++++++++
 tb/tb_ssd1306_vga_top.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_vga_top.sv
// SSD1306-style SPI bitmap receiver feeding a 640x480@60 VGA scanner.
// Each 128x96 bitmap pixel is shown as a 5x5 block of screen pixels.
`timescale 1ns/1ps

module bitmap_ram #(
    parameter int DEPTH = 1536,
    parameter int AW    = 11
) (
    input  logic          Clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);
    logic [7:0] Memory [0:DEPTH-1] = '{default: 8'h00};

    // Read-before-write: a same-cycle collision returns the old byte.
    always_ff @(posedge Clock) begin
        if (i_we) Memory[i_waddr] <= i_wdata;
        o_rdata <= Memory[i_raddr];
    end
endmodule

module vga_timing #(
    parameter int WIDTH = 128,
    parameter int SCALE = 5,
    parameter int AW    = 11
) (
    input  logic          Clock,
    input  logic          Reset,
    output logic [AW-1:0] o_raddr,
    output logic [2:0]    o_bit,
    output logic          o_visible,
    output logic          o_hsync_n,
    output logic          o_vsync_n
);
    localparam logic [2:0] SUB_MAX = 3'(SCALE - 1);

    logic [9:0] HCounter, VCounter;
    logic [2:0] r_hsub, r_vsub;
    logic [7:0] r_xpix, r_ypix;
    logic       w_hend, w_vend;

    assign w_hend = (HCounter == 10'd799);
    assign w_vend = (VCounter == 10'd524);

    // Sub-pixel counters step the bitmap coordinate every SCALE screen pixels.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            HCounter <= '0;
            VCounter <= '0;
            r_hsub   <= '0;
            r_vsub   <= '0;
            r_xpix   <= '0;
            r_ypix   <= '0;
        end else if (w_hend) begin
            HCounter <= '0;
            r_hsub   <= '0;
            r_xpix   <= '0;
            if (w_vend) begin
                VCounter <= '0;
                r_vsub   <= '0;
                r_ypix   <= '0;
            end else begin
                VCounter <= VCounter + 10'd1;
                if (r_vsub == SUB_MAX) begin
                    r_vsub <= '0;
                    r_ypix <= r_ypix + 8'd1;
                end else begin
                    r_vsub <= r_vsub + 3'd1;
                end
            end
        end else begin
            HCounter <= HCounter + 10'd1;
            if (r_hsub == SUB_MAX) begin
                r_hsub <= '0;
                r_xpix <= r_xpix + 8'd1;
            end else begin
                r_hsub <= r_hsub + 3'd1;
            end
        end
    end

    assign o_visible = (HCounter < 10'd640) && (VCounter < 10'd480);
    assign o_hsync_n = !((HCounter >= 10'd656) && (HCounter < 10'd752));
    assign o_vsync_n = !((VCounter >= 10'd490) && (VCounter < 10'd492));
    assign o_bit     = r_ypix[2:0];
    // Page-major layout: page = y/8, one byte per column within a page.
    assign o_raddr   = o_visible ? (AW'(r_ypix[7:3]) * AW'(WIDTH) + AW'(r_xpix)) : '0;
endmodule

module ssd1306_vga_top #(
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 96,
    parameter int SCALE  = 5
) (
    input  logic Clock,
    input  logic Reset,
    input  logic CS_i,
    input  logic SCK_i,
    input  logic MOSI_i,
    input  logic DC_i,
    output logic HSync_o,
    output logic VSync_o,
    output logic Red_o,
    output logic Green_o,
    output logic Blue_o
);
    localparam int DEPTH = WIDTH * HEIGHT / 8;
    localparam int AW    = $clog2(DEPTH);

    logic [1:0]    r_cs_sync, r_sck_sync, r_mosi_sync, r_dc_sync;
    logic          r_sck_d;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [AW-1:0] r_waddr;
    logic          w_sck_rise, w_cs_n, w_we;
    logic [7:0]    w_byte;

    assign w_cs_n     = r_cs_sync[1];
    assign w_sck_rise = r_sck_sync[1] & ~r_sck_d;
    assign w_byte     = {r_shift[6:0], r_mosi_sync[1]};
    assign w_we       = w_sck_rise & ~w_cs_n & (r_bitcnt == 3'd7) & r_dc_sync[1];

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_cs_sync   <= 2'b11;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_dc_sync   <= '0;
            r_sck_d     <= 1'b0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_waddr     <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], CS_i};
            r_sck_sync  <= {r_sck_sync[0], SCK_i};
            r_mosi_sync <= {r_mosi_sync[0], MOSI_i};
            r_dc_sync   <= {r_dc_sync[0], DC_i};
            r_sck_d     <= r_sck_sync[1];
            // Deselect drops any partial byte and rewinds to byte 0.
            if (w_cs_n) begin
                r_bitcnt <= '0;
                r_waddr  <= '0;
            end else if (w_sck_rise) begin
                r_shift  <= w_byte;
                r_bitcnt <= r_bitcnt + 3'd1;
                if (w_we) r_waddr <= (r_waddr == AW'(DEPTH - 1)) ? '0 : r_waddr + 1'b1;
            end
        end
    end

    logic [AW-1:0] w_raddr;
    logic [2:0]    w_bit;
    logic          w_visible, w_hsync_n, w_vsync_n;
    logic [7:0]    w_rdata;

    bitmap_ram #(.DEPTH(DEPTH), .AW(AW)) BitmapRAM (
        .Clock   (Clock),
        .i_we    (w_we),
        .i_waddr (r_waddr),
        .i_wdata (w_byte),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    vga_timing #(.WIDTH(WIDTH), .SCALE(SCALE), .AW(AW)) VGA_inst (
        .Clock     (Clock),
        .Reset     (Reset),
        .o_raddr   (w_raddr),
        .o_bit     (w_bit),
        .o_visible (w_visible),
        .o_hsync_n (w_hsync_n),
        .o_vsync_n (w_vsync_n)
    );

    // Syncs ride a 2-deep shift register to match RAM latency plus the colour register.
    logic [1:0] r_hs_pipe, r_vs_pipe;
    logic       r_vis_d, r_color;
    logic [2:0] r_bit_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_hs_pipe <= 2'b11;
            r_vs_pipe <= 2'b11;
            r_vis_d   <= 1'b0;
            r_bit_d   <= '0;
            r_color   <= 1'b0;
        end else begin
            r_hs_pipe <= {r_hs_pipe[0], w_hsync_n};
            r_vs_pipe <= {r_vs_pipe[0], w_vsync_n};
            r_vis_d   <= w_visible;
            r_bit_d   <= w_bit;
            r_color   <= r_vis_d & w_rdata[r_bit_d];
        end
    end

    assign HSync_o = r_hs_pipe[1];
    assign VSync_o = r_vs_pipe[1];
    assign Red_o   = r_color;
    assign Green_o = r_color;
    assign Blue_o  = r_color;
endmodule

// File: tb/tb_ssd1306_vga_top.sv
// Randomised SPI traffic into ssd1306_vga_top, checked cycle by cycle against
// an arithmetic screen model (pixel = mem[(y/8)*128+x] bit y%8, x=h/5, y=v/5).
`timescale 1ns/1ps

module tb_ssd1306_vga_top;
    logic Clock = 1'b0, Reset = 1'b0;
    logic CS_i = 1'b1, SCK_i = 1'b0, MOSI_i = 1'b0, DC_i = 1'b0;
    logic HSync_o, VSync_o, Red_o, Green_o, Blue_o;

    ssd1306_vga_top dut (
        .Clock(Clock), .Reset(Reset), .CS_i(CS_i), .SCK_i(SCK_i), .MOSI_i(MOSI_i), .DC_i(DC_i),
        .HSync_o(HSync_o), .VSync_o(VSync_o), .Red_o(Red_o), .Green_o(Green_o), .Blue_o(Blue_o)
    );

    always #20 Clock = ~Clock;

    int   n_chk = 0, n_fail = 0;
    int   k = 0;
    bit   mon_en = 0, pix_chk = 0;
    logic [7:0] m_mem [0:1535];
    int   m_addr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_pix(input int n);
        int h, v, x, y;
        logic [7:0] b;
        h = n % 800;
        v = (n / 800) % 525;
        if (h >= 640 || v >= 480) return 1'b0;
        x = h / 5;
        y = v / 5;
        b = m_mem[(y / 8) * 128 + x];
        return b[y % 8];
    endfunction

    // Rising edges seen with reset released
    always @(posedge Clock) k <= Reset ? k + 1 : 0;

    always @(negedge Clock) begin
        if (mon_en) begin
            chk("hcnt", 32'(dut.VGA_inst.HCounter), k % 800);
            chk("vcnt", 32'(dut.VGA_inst.VCounter), (k / 800) % 525);
            if (k >= 2) begin
                int n, h, v;
                n = k - 2;
                h = n % 800;
                v = (n / 800) % 525;
                chk("hsync", HSync_o, (h >= 656 && h <= 751) ? 0 : 1);
                chk("vsync", VSync_o, (v >= 490 && v <= 491) ? 0 : 1);
                if (pix_chk) chk("rgb", {Red_o, Green_o, Blue_o}, exp_pix(n) ? 3'b111 : 3'b000);
            end else begin
                chk("hsync_k1", HSync_o, 1);
                chk("vsync_k1", VSync_o, 1);
                chk("rgb_k1", {Red_o, Green_o, Blue_o}, 0);
            end
        end
    end

    task automatic cs_low();
        pix_chk = 0;
        CS_i = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #100 CS_i = 1'b1;
        m_addr = 0;
        repeat (10) @(negedge Clock);
        pix_chk = 1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic dc, input int nb);
        DC_i = dc;
        for (int i = 7; i > 7 - nb; i--) begin
            MOSI_i = b[i];
            #100 SCK_i = 1'b1;
            #100 SCK_i = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dc);
        send_bits(b, dc, 8);
        if (dc) begin
            m_mem[m_addr] = b;
            m_addr = (m_addr + 1) % 1536;
        end
    endtask

    task automatic wait_cyc(input int c);
        repeat (c) @(negedge Clock);
    endtask

    initial begin
        logic [7:0] pat [0:7];
        logic [7:0] rb;
        int c, lo;
        for (int i = 0; i < 1536; i++) m_mem[i] = 8'h00;

        // Reset held for two edges
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        chk("rst_hsync", HSync_o, 1);
        chk("rst_vsync", VSync_o, 1);
        chk("rst_rgb", {Red_o, Green_o, Blue_o}, 0);
        chk("rst_hcnt", 32'(dut.VGA_inst.HCounter), 0);
        chk("rst_vcnt", 32'(dut.VGA_inst.VCounter), 0);
        chk("rst_bitcnt", 32'(dut.r_bitcnt), 0);
        chk("rst_waddr", 32'(dut.r_waddr), 0);
        Reset = 1'b1;
        mon_en = 1;
        pix_chk = 1;

        // Partial byte then deselect: nothing written
        cs_low();
        rb = 8'($urandom_range(1, 255));
        send_bits(rb, 1'b1, 5);
        cs_high();
        chk("partial_mem0", dut.BitmapRAM.Memory[0], 8'h00);
        chk("partial_bitcnt", 32'(dut.r_bitcnt), 0);

        // Single lit pixel at bitmap (0,0)
        cs_low();
        send_byte(8'h01, 1'b1);
        cs_high();
        chk("one_mem0", dut.BitmapRAM.Memory[0], 8'h01);
        chk("one_mem1", dut.BitmapRAM.Memory[1], 8'h00);

        // HSync pulse width, start position and line period
        c = 0;
        while (HSync_o !== 1'b1 && c < 2000) begin @(negedge Clock); c++; end
        while (HSync_o !== 1'b0 && c < 2000) begin @(negedge Clock); c++; end
        chk("hs_fall_found", c < 2000, 1);
        chk("hs_fall_h", 32'(dut.VGA_inst.HCounter), 658);
        lo = 0;
        while (HSync_o === 1'b0 && lo < 2000) begin @(negedge Clock); lo++; end
        chk("hs_low_len", lo, 96);
        c = lo;
        while (HSync_o === 1'b1 && c < 2000) begin @(negedge Clock); c++; end
        chk("hs_period", c, 800);

        // Eight graded bytes
        pat = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        cs_low();
        for (int i = 0; i < 8; i++) send_byte(pat[i], 1'b1);
        cs_high();
        for (int i = 0; i < 8; i++) chk($sformatf("grad_mem%0d", i), dut.BitmapRAM.Memory[i], pat[i]);

        // Command byte between data bytes is dropped
        cs_low();
        send_byte(8'h11, 1'b1);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h22, 1'b1);
        cs_high();
        chk("dc_mem0", dut.BitmapRAM.Memory[0], 8'h11);
        chk("dc_mem1", dut.BitmapRAM.Memory[1], 8'h22);
        chk("dc_mem2", dut.BitmapRAM.Memory[2], 8'h07);

        // Random bytes into a few columns, then compare
        cs_low();
        for (int i = 0; i < 24; i++) send_byte(8'($urandom), 1'b1);
        cs_high();
        for (int i = 0; i < 24; i++) chk($sformatf("rnd_mem%0d", i), dut.BitmapRAM.Memory[i], m_mem[i]);

        // Full frame of FF, then one extra byte wraps to address 0
        cs_low();
        for (int i = 0; i < 1536; i++) send_byte(8'hFF, 1'b1);
        wait_cyc(4);
        chk("full_mem0", dut.BitmapRAM.Memory[0], 8'hFF);
        chk("full_mem1", dut.BitmapRAM.Memory[1], 8'hFF);
        chk("full_mem767", dut.BitmapRAM.Memory[767], 8'hFF);
        chk("full_mem1535", dut.BitmapRAM.Memory[1535], 8'hFF);
        send_byte(8'h3C, 1'b1);
        cs_high();
        chk("wrap_mem0", dut.BitmapRAM.Memory[0], 8'h3C);
        chk("wrap_mem1", dut.BitmapRAM.Memory[1], 8'hFF);
        chk("wrap_mem1535", dut.BitmapRAM.Memory[1535], 8'hFF);

        // White visible area, black blanking, checked by the monitor
        wait_cyc(2400);
        @(negedge Clock);
        chk("white_pix", {Red_o, Green_o, Blue_o}, exp_pix(k - 2) ? 3'b111 : 3'b000);

        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
